// File: rtl/feat_pkg.sv
// Shared constants and types for the feature-window datapath.
// The five block sums of one window feed the 40-bit five-input feature adder.
package feat_pkg;
   localparam int FEAT_DATA_WIDTH = 32;
   localparam int FEAT_BLOCK_LEN  = 32;
   localparam int FEAT_SUM_WIDTH  = 37;
   localparam int FEAT_OUT_WIDTH  = 40;
   localparam int FEAT_WIN_DEPTH  = 5;

   typedef logic signed [FEAT_SUM_WIDTH-1:0] feat_sum_t;
endpackage

// File: rtl/block_accum.sv
// Accumulates BLOCK_LEN accepted samples into one block sum.
// The sum and the close pulse are combinational so the top can register them.
module block_accum
   import feat_pkg::*;
#(
   parameter int DATA_WIDTH = FEAT_DATA_WIDTH,
   parameter int BLOCK_LEN  = FEAT_BLOCK_LEN,
   parameter int SUM_WIDTH  = FEAT_SUM_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clr,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         din_valid,
   output logic signed [SUM_WIDTH-1:0]  block_sum,
   output logic                         block_done
);
   localparam int              CNT_W    = $clog2(BLOCK_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
   logic signed [SUM_WIDTH-1:0] din_ext;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        accept;

   // din_valid qualifies din; there is no ready, a sample is taken whenever en is high and clr is low.
   assign accept     = en & din_valid & ~clr;
   assign din_ext    = {{(SUM_WIDTH-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
   assign block_sum  = acc_q + din_ext;
   assign block_done = accept && (cnt_q == CNT_LAST);

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (block_done) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         acc_d = block_sum;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/feat_window5.sv
// Sliding five-block window: keeps the five newest block sums and strobes
// dout_valid on every block close once the history is full.
module feat_window5
   import feat_pkg::*;
#(
   parameter int DATA_WIDTH = FEAT_DATA_WIDTH,
   parameter int BLOCK_LEN  = FEAT_BLOCK_LEN,
   parameter int SUM_WIDTH  = FEAT_SUM_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clr,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         din_valid,
   output logic signed [SUM_WIDTH-1:0]  win1,
   output logic signed [SUM_WIDTH-1:0]  win2,
   output logic signed [SUM_WIDTH-1:0]  win3,
   output logic signed [SUM_WIDTH-1:0]  win4,
   output logic signed [SUM_WIDTH-1:0]  win5,
   output logic                         dout_valid
);
   localparam logic [2:0] FILL_MAX = 3'(FEAT_WIN_DEPTH);

   logic signed [SUM_WIDTH-1:0] block_sum;
   logic                        block_done;
   logic signed [SUM_WIDTH-1:0] win_q [FEAT_WIN_DEPTH];
   logic [2:0]                  fill_q, fill_d;
   logic                        dout_valid_q;

   block_accum #(
      .DATA_WIDTH (DATA_WIDTH),
      .BLOCK_LEN  (BLOCK_LEN),
      .SUM_WIDTH  (SUM_WIDTH)
   ) u_accum (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .din        (din),
      .din_valid  (din_valid),
      .block_sum  (block_sum),
      .block_done (block_done)
   );

   assign fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 3'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < FEAT_WIN_DEPTH; k++) win_q[k] <= '0;
         fill_q       <= '0;
         dout_valid_q <= 1'b0;
      end else if (clr) begin
         for (int k = 0; k < FEAT_WIN_DEPTH; k++) win_q[k] <= '0;
         fill_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_valid_q <= 1'b0;
         if (block_done) begin
            // Index 0 is the newest block; the oldest falls off the end.
            win_q[0] <= block_sum;
            for (int k = 1; k < FEAT_WIN_DEPTH; k++) win_q[k] <= win_q[k-1];
            fill_q       <= fill_d;
            dout_valid_q <= (fill_d == FILL_MAX);
         end
      end
   end

   assign win1       = win_q[0];
   assign win2       = win_q[1];
   assign win3       = win_q[2];
   assign win4       = win_q[3];
   assign win5       = win_q[4];
   assign dout_valid = dout_valid_q;
endmodule

// File: doc/feat_window5.md
# feat_window5

Block-summing window stage that feeds the five-input feature adder. Consumes a stream of signed per-sample feature values (energy or line-length terms), accumulates them into block sums of `BLOCK_LEN` samples, and keeps the five most recent block sums in a history register. Once five block sums exist, it presents them in parallel with a one-cycle valid strobe. The adder's 40-bit output is then the feature value over a sliding window of 5 × `BLOCK_LEN` samples.

## Interface
- `DATA_WIDTH`, 32: width of the signed input sample.
- `BLOCK_LEN`, 32: samples per block; power of two, ≥ 2.
- `SUM_WIDTH`, 37: width of each block sum; must be ≥ `DATA_WIDTH` + log2(`BLOCK_LEN`).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: stage enable; while low the stage holds all state.
- `clr` in 1: synchronous flush of the accumulator, counter, history and fill count.
- `din` in `DATA_WIDTH`: signed sample.
- `din_valid` in 1: qualifies `din`.
- `win1`..`win5` out `SUM_WIDTH` each: signed block sums; `win1` is the newest, `win5` the oldest. Wire directly to adder `din1`..`din5`.
- `dout_valid` out 1: one-cycle strobe; `win1`..`win5` form a complete new window.

## Operation
- State:
  - `acc`: signed, `SUM_WIDTH` bits.
  - `cnt`: 0..`BLOCK_LEN`-1.
  - `fill`: 0..5.
  - History: `win1`..`win5`.
- Sample acceptance: a sample is accepted when `en` & `din_valid` & !`clr`. `din` is sign-extended to `SUM_WIDTH` before it is added.
- Accepted sample with `cnt` < `BLOCK_LEN`-1: `acc` <= `acc` + `din`; `cnt` += 1.
- Accepted sample with `cnt` == `BLOCK_LEN`-1 (block close):
  - History shift: `win1` <= `acc` + `din`; `winK` <= `winK-1` for K = 2..5.
  - `acc` <= 0; `cnt` <= 0.
  - `fill` <= min(`fill`+1, 5).
  - `dout_valid` <= 1 if the new `fill` value is 5.
- In every other cycle `dout_valid` <= 0. It never stays high for two consecutive cycles.
- Window behaviour: after the first full window, every block close produces a strobe. The window slides by one block per strobe.
- `clr` high: `acc`, `cnt`, `fill`, `win1`..`win5` and `dout_valid` go to 0 on the next edge.
  - `clr` takes priority over `en` and `din_valid`; the sample presented in that cycle is dropped.
- `en` low: all state is held, `din` is ignored, and `dout_valid` is 0. A block may span any number of `en`/`din_valid` gaps.
- Arithmetic: no saturation. The `SUM_WIDTH` rule guarantees no overflow, for example 32 × (−2^31) = −2^36 fits in 37 bits.

## Timing
- Reset value of every output: 0. `rst` low clears all registers immediately, with no clock edge required, including in the middle of a block.
- Latency: the block sum appears on `win1`, together with `dout_valid` when `fill` reaches 5, in the cycle after the edge that accepts the last sample of the block.
- First strobe: follows the 5 × `BLOCK_LEN`-th accepted sample after reset or `clr`.
- Throughput: one sample per cycle; no backpressure.
- Downstream timing: the adder is combinational, so the window sum is valid in the same cycle as `dout_valid`.
- `win1`..`win5` change only at block close or on clear.

## Structure
- Shared package `feat_pkg` holds:
  - `FEAT_DATA_WIDTH` (32), `FEAT_BLOCK_LEN` (32), `FEAT_SUM_WIDTH` (37), `FEAT_OUT_WIDTH` (40).
  - `FEAT_WIN_DEPTH` (5).
  - Signed typedef `feat_sum_t`.
- Sub-module `block_accum`: accumulator, counter and block-close pulse. It outputs `block_sum` and `block_done`.
- The top level contains the 5-deep history, the `fill` counter and `dout_valid` generation.

## Test plan
All scenarios use `BLOCK_LEN` = 4 unless stated otherwise.
- Reset: assert `rst` = 0 with no clock running. All `win` outputs = 0 and `dout_valid` = 0 immediately.
- Window fill: 20 consecutive samples of +1. No strobe before the 20th sample; after it, `dout_valid` is a single pulse and `win1`..`win5` = 4. Four further samples of +2 give `win1` = 8, `win2`..`win5` = 4, and one more pulse.
- Signed values: after a full window, one block of −5 ×4. `win1` = −20, with all `SUM_WIDTH` bits set correctly for sign extension, and the remaining windows shifted by one.
- Gaps: interleave `din_valid` = 0 cycles and `en` = 0 cycles, with `din` randomised during them. Sums and strobe timing match the gap-free run, counted in accepted samples.
- Clears: `clr` after 2 samples of block 3 clears all outputs, and the next strobe arrives only after 20 new samples. A separate run applies `rst` low at the same point with the same result.
- Width limit: `BLOCK_LEN` = 32 with 32 samples of −2^31. `win1` = −2^36 exactly, with no wrap.
